// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: folds a valid/ready burst of words with AND/OR/XOR/NAND into one result plus word count
module logic_reduce_unit #(
  parameter int WIDTH = 16,
  parameter int MAX_WORDS = 8,
  localparam int CNT_W = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d, fold;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_count_q, out_count_d, cnt_nxt;
  logic [1:0] op_q, op_d, op_e;
  logic first, beat, close;
  assign in_ready = state_q != DONE;
  assign out_valid = state_q == DONE;
  assign out_data = out_data_q;
  assign out_count = out_count_q;
  always_comb begin
    first = state_q == IDLE;
    beat = in_valid && in_ready;
    op_e = first ? op : op_q;
    fold = first ? in_data : op_e == 2'b01 ? acc_q | in_data : op_e == 2'b10 ? acc_q ^ in_data : acc_q & in_data;
    cnt_nxt = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
    close = in_last || cnt_nxt == CNT_W'(MAX_WORDS);
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    op_d = op_q;
    out_data_d = out_data_q;
    out_count_d = out_count_q;
    if (beat) begin
      acc_d = fold;
      cnt_d = cnt_nxt;
      op_d = op_e;
      state_d = close ? DONE : ACCUM;
      out_data_d = close ? (op_e == 2'b11 ? ~fold : fold) : out_data_q;
      out_count_d = close ? cnt_nxt : out_count_q;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      op_q <= '0;
      out_data_q <= '0;
      out_count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      out_data_q <= out_data_d;
      out_count_q <= out_count_d;
    end
  end
endmodule

// File: tb/tb_logic_reduce_unit.sv
// tb_logic_reduce_unit: directed checks of logic_reduce_unit with WIDTH=16, MAX_WORDS=4
module tb_logic_reduce_unit;
  logic clk = 0, reset = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [1:0] op = 0;
  logic [15:0] in_data = 0;
  logic in_ready, out_valid;
  logic [15:0] out_data;
  logic [2:0] out_count;
  int checks = 0, errors = 0;
  logic [15:0] held_data;
  logic [2:0] held_count;
  logic_reduce_unit #(.WIDTH(16), .MAX_WORDS(4)) dut (
    .clk(clk), .reset(reset), .op(op), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [1:0] o, input logic [15:0] d, input logic l);
    op = o;
    in_data = d;
    in_last = l;
    in_valid = 1;
    chk("beat_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic result(input string tag, input logic [15:0] d, input logic [2:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
  endtask
  task automatic take(input string tag);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({tag, "_valid_low"}, 32'(out_valid), 0);
    chk({tag, "_ready_high"}, 32'(in_ready), 1);
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_count", 32'(out_count), 0);
    beat(2'b00, 16'hFFFF, 0);
    beat(2'b00, 16'h0F0F, 0);
    chk("accum_no_valid", 32'(out_valid), 0);
    beat(2'b00, 16'h00FF, 1);
    result("and3", 16'h000F, 3);
    take("and3");
    chk("and3_keep_data", 32'(out_data), 32'h000F);
    chk("and3_keep_count", 32'(out_count), 3);
    beat(2'b10, 16'hA5A5, 1);
    result("xor1", 16'hA5A5, 1);
    take("xor1");
    beat(2'b11, 16'h1234, 1);
    result("nand1", 16'hEDCB, 1);
    take("nand1");
    beat(2'b11, 16'hFF00, 0);
    beat(2'b11, 16'h0FF0, 1);
    result("nand2", 16'hF0FF, 2);
    take("nand2");
    beat(2'b01, 16'h0001, 0);
    beat(2'b01, 16'h0002, 0);
    beat(2'b01, 16'h0004, 0);
    beat(2'b01, 16'h0008, 0);
    result("cap", 16'h000F, 4);
    held_data = out_data;
    held_count = out_count;
    op = 2'b00;
    in_data = 16'h0010;
    in_last = 1;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'(held_data));
      chk("bp_count", 32'(out_count), 32'(held_count));
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    take("cap");
    tick();
    in_valid = 0;
    in_last = 0;
    result("held", 16'h0010, 1);
    take("held");
    beat(2'b00, 16'h00FF, 0);
    beat(2'b00, 16'h0F0F, 0);
    reset = 1;
    in_valid = 1;
    in_data = 16'h1111;
    in_last = 1;
    tick();
    reset = 0;
    in_valid = 0;
    in_last = 0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_count", 32'(out_count), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    beat(2'b00, 16'h00F0, 1);
    result("post_rst", 16'h00F0, 1);
    take("post_rst");
    beat(2'b01, 16'h0001, 0);
    tick();
    chk("hold_no_valid", 32'(out_valid), 0);
    beat(2'b00, 16'h0100, 1);
    result("op_ignored", 16'h0101, 2);
    take("op_ignored");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
